alu_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_mult_seq.sv | 68 ++++++
 rtl/alu_seq.sv | 207 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types for the sequential ALU
//
// Holds the operation encoding, the control FSM state type and the
// flag bundle used by alu_seq and its multiplier.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/alu_mult_seq.sv
// rtl/alu_mult_seq.sv - WIDTH-cycle unsigned shift-add multiplier
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        one-cycle pulse; a and b are sampled on this edge
//   a, b         multiplicand, multiplier
//   done         one-cycle pulse when product is final
//   product      2*WIDTH-bit unsigned product, valid while done is high
//
// The first shift-add step happens on the start edge itself, so the last
// of the WIDTH steps lands one cycle earlier and the parent FSM can
// register the product on the edge after done.
module alu_mult_seq #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] mcand;
    logic [CW-1:0]    cnt;
    logic             busy;

    // One step: add the multiplicand into the upper half when the current
    // multiplier LSB is set, then shift the whole register right by one.
    // The upper half is WIDTH+1 wide so the add carry is shifted in.
    function automatic logic [2*WIDTH-1:0] step(
        input logic [2*WIDTH-1:0] p,
        input logic [WIDTH-1:0]   m
    );
        logic [WIDTH:0] sum;
        sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, m & {WIDTH{p[0]}}};
        return {sum, p[WIDTH-1:1]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            product <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                mcand   <= a;
                product <= step({{WIDTH{1'b0}}, b}, a);
                cnt     <= CW'(WIDTH - 1);
                busy    <= 1'b1;
            end else if (busy) begin
                product <= step(product, mcand);
                cnt     <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - parametrised sequential ALU with handshake and multi-cycle MUL
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  operand handshake; in_ready is high only in IDLE
//   a, b, op            operands and operation (alu_op_t); b[SHW-1:0] is the shift amount
//   out_valid, out_ready result handshake; outputs are held until out_ready
//   r, r_hi             result (low half for MUL), MUL high half (0 otherwise)
//   N, Z, C, V          negative, zero, carry, overflow flags
//
// Build option: ALU_ABS_SUB_EN makes SUB return |a - b| with N marking a < b.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] r_hi,
    output logic             N,
    output logic             Z,
    output logic             C,
    output logic             V
);

    localparam int MSB = WIDTH - 1;
    // WIDTH always fits in SHW+1 bits, so this compare detects shift
    // amounts >= WIDTH when WIDTH is not a power of two.
    localparam logic [SHW:0] WIDTH_L = (SHW + 1)'(WIDTH);

    state_t     state, next_state;
    alu_op_t    op_e;
    alu_flags_t flags_q;

    logic       mul_start;
    logic       mul_done;
    logic       load_alu;
    logic [2*WIDTH-1:0] mul_product;

    assign op_e = alu_op_t'(op);

    // ------------------------------------------------------------------
    // Single-cycle datapath, evaluated on the live inputs and registered
    // on the accepting edge.
    // ------------------------------------------------------------------
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [SHW-1:0]   amt;
    logic             amt_oob;
    logic [WIDTH:0]   shl_full;
    logic [WIDTH:0]   shr_full;
    logic [WIDTH-1:0] alu_r;
    alu_flags_t       alu_f;

    // sub_full[WIDTH] is the carry of a + ~b + 1, i.e. 1 when no borrow.
    assign add_full = {1'b0, a} + {1'b0, b};
    assign sub_full = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign amt      = b[SHW-1:0];
    assign amt_oob  = {1'b0, amt} >= WIDTH_L;
    // The extra bit catches the last bit shifted out; a zero shift leaves it 0.
    assign shl_full = {1'b0, a} << amt;
    assign shr_full = {a, 1'b0} >> amt;

    always_comb begin
        alu_r = '0;
        alu_f = '0;
        case (op_e)
            OP_ADD: begin
                alu_r   = add_full[WIDTH-1:0];
                alu_f.c = add_full[WIDTH];
                alu_f.v = (a[MSB] == b[MSB]) && (alu_r[MSB] != a[MSB]);
            end
            OP_SUB: begin
`ifdef ALU_ABS_SUB_EN
                alu_r   = sub_full[WIDTH] ? sub_full[WIDTH-1:0] : (b - a);
                alu_f.c = sub_full[WIDTH];
`else
                alu_r   = sub_full[WIDTH-1:0];
                alu_f.c = sub_full[WIDTH];
                alu_f.v = (a[MSB] != b[MSB]) && (alu_r[MSB] != a[MSB]);
`endif
            end
            OP_AND: alu_r = a & b;
            OP_OR:  alu_r = a | b;
            OP_XOR: alu_r = a ^ b;
            OP_SHL: begin
                if (!amt_oob) begin
                    alu_r   = shl_full[WIDTH-1:0];
                    alu_f.c = shl_full[WIDTH];
                end
            end
            OP_SHR: begin
                if (!amt_oob) begin
                    alu_r   = shr_full[WIDTH:1];
                    alu_f.c = shr_full[0];
                end
            end
            default: ;  // MUL goes through alu_mult_seq
        endcase
        alu_f.n = alu_r[MSB];
`ifdef ALU_ABS_SUB_EN
        // Magnitude result: N reports the sign of a - b instead of r's MSB.
        if (op_e == OP_SUB) begin
            alu_f.n = !sub_full[WIDTH];
        end
`endif
        alu_f.z = (alu_r == '0);
    end

    // ------------------------------------------------------------------
    // Multiplier
    // ------------------------------------------------------------------
    alu_mult_seq #(
        .WIDTH(WIDTH)
    ) u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        mul_start  = 1'b0;
        load_alu   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (op_e == OP_MUL) begin
                        mul_start  = 1'b1;
                        next_state = MUL;
                    end else begin
                        load_alu   = 1'b1;
                        next_state = DONE;
                    end
                end
            end
            MUL: begin
                if (mul_done) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Result and flag registers; only written on completion, so they hold
    // steady through DONE regardless of the input side.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r       <= '0;
            r_hi    <= '0;
            flags_q <= '0;
        end else if (load_alu) begin
            r       <= alu_r;
            r_hi    <= '0;
            flags_q <= alu_f;
        end else if ((state == MUL) && mul_done) begin
            r         <= mul_product[WIDTH-1:0];
            r_hi      <= mul_product[2*WIDTH-1:WIDTH];
            flags_q.n <= mul_product[WIDTH-1];
            flags_q.z <= (mul_product[WIDTH-1:0] == '0);
            flags_q.c <= (mul_product[2*WIDTH-1:WIDTH] != '0);
            flags_q.v <= (mul_product[2*WIDTH-1:WIDTH] != '0);
        end
    end

    assign N = flags_q.n;
    assign Z = flags_q.z;
    assign C = flags_q.c;
    assign V = flags_q.v;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq (WIDTH=4)
module tb_alu_seq;

    localparam int W     = 4;
    localparam int MODV  = 1 << W;
    localparam int HALF  = 1 << (W - 1);
    localparam int SHMOD = 1 << $clog2(W);
    localparam int VW    = 2 * W + 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] r;
    logic [W-1:0] r_hi;
    logic         N, Z, C, V;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .r_hi      (r_hi),
        .N         (N),
        .Z         (Z),
        .C         (C),
        .V         (V)
    );

    // Reference model from the arithmetic rules; result packed {r_hi, r, N, Z, C, V}.
    function automatic logic [VW-1:0] model(input int ta, input int tb_, input int top);
        int res, hi, sa, sb, sr, s, p;
        logic n, z, c, v;
        res = 0; hi = 0; sr = 0; p = 0;
        c = 1'b0; v = 1'b0;
        sa = (ta >= HALF) ? ta - MODV : ta;
        sb = (tb_ >= HALF) ? tb_ - MODV : tb_;
        s  = tb_ % SHMOD;
        case (top)
            0: begin
                res = ta + tb_;
                c   = (res >= MODV);
                sr  = sa + sb;
                v   = (sr >= HALF) || (sr < -HALF);
                res = res % MODV;
            end
            1: begin
`ifdef ALU_ABS_SUB_EN
                res = (ta >= tb_) ? ta - tb_ : tb_ - ta;
                c   = (ta >= tb_);
`else
                res = (ta - tb_ + MODV) % MODV;
                c   = (ta >= tb_);
                sr  = sa - sb;
                v   = (sr >= HALF) || (sr < -HALF);
`endif
            end
            2: res = ta & tb_;
            3: res = ta | tb_;
            4: res = ta ^ tb_;
            5: if (s < W) begin
                res = (ta << s) % MODV;
                c   = (s > 0) ? (((ta >> (W - s)) & 1) != 0) : 1'b0;
            end
            6: if (s < W) begin
                res = ta >> s;
                c   = (s > 0) ? (((ta >> (s - 1)) & 1) != 0) : 1'b0;
            end
            default: begin
                p   = ta * tb_;
                res = p % MODV;
                hi  = p / MODV;
                c   = (hi != 0);
                v   = c;
            end
        endcase
        n = (res >= HALF);
`ifdef ALU_ABS_SUB_EN
        if (top == 1) n = (ta < tb_);
`endif
        z = (res == 0);
        return {hi[W-1:0], res[W-1:0], n, z, c, v};
    endfunction

    // Drives one transaction from IDLE and returns observed outputs and latency.
    task automatic do_txn(input int ta, input int tb_, input int top,
                          output logic [VW-1:0] got, output int lat);
        a        = ta[W-1:0];
        b        = tb_[W-1:0];
        op       = top[2:0];
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        got       = {r_hi, r, N, Z, C, V};
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10)
            $display("FAIL reset_hs got=%b exp=10", {in_ready, out_valid});
        checks++;
        if ({r_hi, r, N, Z, C, V} !== {VW{1'b0}})
            $display("FAIL reset_out got=%h exp=0", {r_hi, r, N, Z, C, V});
        if ({r_hi, r, N, Z, C, V} !== {VW{1'b0}}) errors++;
        if ({in_ready, out_valid} !== 2'b10) errors++;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got=%b exp=10", {in_ready, out_valid});
        end
    endtask

    task automatic test_add();
        logic [VW-1:0] got;
        int lat;
        do_txn(7, 1, 0, got, lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL add_latency got=%0d exp=1", lat); end
        checks++;
        if (got !== {4'd0, 4'd8, 4'b1001}) begin errors++; $display("FAIL add_ovf got=%h exp=%h", got, {4'd0, 4'd8, 4'b1001}); end
        do_txn(15, 1, 0, got, lat);
        checks++;
        if (got !== {4'd0, 4'd0, 4'b0110}) begin errors++; $display("FAIL add_wrap got=%h exp=%h", got, {4'd0, 4'd0, 4'b0110}); end
    endtask

    task automatic test_sub();
        logic [VW-1:0] got, exp1, exp2, exp3, exp4;
        int lat;
`ifdef ALU_ABS_SUB_EN
        exp1 = {4'd0, 4'd2, 4'b1000};
        exp4 = {4'd0, 4'd7, 4'b0010};
`else
        exp1 = {4'd0, 4'd14, 4'b1000};
        exp4 = {4'd0, 4'd7, 4'b0011};
`endif
        exp2 = {4'd0, 4'd2, 4'b0010};
        exp3 = {4'd0, 4'd0, 4'b0110};
        do_txn(3, 5, 1, got, lat);
        checks++;
        if (got !== exp1) begin errors++; $display("FAIL sub_3_5 got=%h exp=%h", got, exp1); end
        do_txn(5, 3, 1, got, lat);
        checks++;
        if (got !== exp2) begin errors++; $display("FAIL sub_5_3 got=%h exp=%h", got, exp2); end
        do_txn(9, 9, 1, got, lat);
        checks++;
        if (got !== exp3) begin errors++; $display("FAIL sub_equal got=%h exp=%h", got, exp3); end
        do_txn(8, 1, 1, got, lat);
        checks++;
        if (got !== exp4) begin errors++; $display("FAIL sub_ovf got=%h exp=%h", got, exp4); end
    endtask

    task automatic test_mul();
        logic [VW-1:0] got;
        int lat;
        do_txn(13, 11, 7, got, lat);
        checks++;
        if (lat !== W + 1) begin errors++; $display("FAIL mul_latency got=%0d exp=%0d", lat, W + 1); end
        checks++;
        if (got !== {4'd8, 4'd15, 4'b1011}) begin errors++; $display("FAIL mul_13_11 got=%h exp=%h", got, {4'd8, 4'd15, 4'b1011}); end
        do_txn(3, 2, 7, got, lat);
        checks++;
        if (got !== {4'd0, 4'd6, 4'b0000}) begin errors++; $display("FAIL mul_3_2 got=%h exp=%h", got, {4'd0, 4'd6, 4'b0000}); end
        do_txn(15, 15, 7, got, lat);
        checks++;
        if (got !== {4'd14, 4'd1, 4'b0011}) begin errors++; $display("FAIL mul_15_15 got=%h exp=%h", got, {4'd14, 4'd1, 4'b0011}); end
        do_txn(0, 9, 7, got, lat);
        checks++;
        if (got !== {4'd0, 4'd0, 4'b0100}) begin errors++; $display("FAIL mul_zero got=%h exp=%h", got, {4'd0, 4'd0, 4'b0100}); end
    endtask

    task automatic test_shift();
        logic [VW-1:0] got;
        int lat;
        do_txn(9, 1, 5, got, lat);
        checks++;
        if (got !== {4'd0, 4'd2, 4'b0010}) begin errors++; $display("FAIL shl_9_1 got=%h exp=%h", got, {4'd0, 4'd2, 4'b0010}); end
        do_txn(9, 0, 6, got, lat);
        checks++;
        if (got !== {4'd0, 4'd9, 4'b1000}) begin errors++; $display("FAIL shr_9_0 got=%h exp=%h", got, {4'd0, 4'd9, 4'b1000}); end
        do_txn(8, 3, 6, got, lat);
        checks++;
        if (got !== {4'd0, 4'd1, 4'b0000}) begin errors++; $display("FAIL shr_8_3 got=%h exp=%h", got, {4'd0, 4'd1, 4'b0000}); end
        do_txn(9, 3, 5, got, lat);
        checks++;
        if (got !== {4'd0, 4'd8, 4'b1000}) begin errors++; $display("FAIL shl_9_3 got=%h exp=%h", got, {4'd0, 4'd8, 4'b1000}); end
        do_txn(6, 2, 6, got, lat);
        checks++;
        if (got !== {4'd0, 4'd1, 4'b0010}) begin errors++; $display("FAIL shr_6_2 got=%h exp=%h", got, {4'd0, 4'd1, 4'b0010}); end
    endtask

    task automatic test_backpressure();
        a = 4'd2; b = 4'd2; op = 3'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            a  = 4'($urandom_range(0, 15));
            b  = 4'($urandom_range(0, 15));
            op = 3'($urandom_range(0, 7));
            checks++;
            if ({out_valid, in_ready, r_hi, r, N, Z, C, V} !== {2'b10, 4'd0, 4'd4, 4'b0000}) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d got=%h exp=%h", i,
                         {out_valid, in_ready, r_hi, r, N, Z, C, V}, {2'b10, 4'd0, 4'd4, 4'b0000});
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL bp_release got=%b exp=10", {in_ready, out_valid}); end
    endtask

    task automatic test_reset_mid_mul();
        logic [VW-1:0] got;
        int lat;
        int seen;
        a = 4'd7; b = 4'd3; op = 3'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b00) begin errors++; $display("FAIL mul_busy got=%b exp=00", {in_ready, out_valid}); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, r_hi, r, N, Z, C, V} !== {2'b10, {VW{1'b0}}}) begin
            errors++;
            $display("FAIL rst_mid_mul got=%h exp=%h", {in_ready, out_valid, r_hi, r, N, Z, C, V}, {2'b10, {VW{1'b0}}});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL rst_no_partial got=%0d exp=0", seen); end
        do_txn(3, 2, 7, got, lat);
        checks++;
        if (got !== {4'd0, 4'd6, 4'b0000} || lat !== W + 1) begin
            errors++;
            $display("FAIL rst_then_mul got=%h lat=%0d exp=%h lat=%0d", got, lat, {4'd0, 4'd6, 4'b0000}, W + 1);
        end
    endtask

    task automatic test_random();
        logic [VW-1:0] got, exp;
        int ta, tb_, top, lat;
        for (int i = 0; i < 40; i++) begin
            ta  = $urandom_range(0, MODV - 1);
            tb_ = $urandom_range(0, MODV - 1);
            top = $urandom_range(0, 7);
            exp = model(ta, tb_, top);
            do_txn(ta, tb_, top, got, lat);
            checks++;
            if (got !== exp || lat !== ((top == 7) ? W + 1 : 1)) begin
                errors++;
                $display("FAIL random op=%0d a=%0d b=%0d got=%h lat=%0d exp=%h", top, ta, tb_, got, lat, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] exp;
        int ta, tb_, top;
        time t0;
        out_ready = 1'b1;
        t0 = $time;
        for (int i = 0; i < 8; i++) begin
            ta  = $urandom_range(0, MODV - 1);
            tb_ = $urandom_range(0, MODV - 1);
            top = $urandom_range(0, 6);
            exp = model(ta, tb_, top);
            a = ta[W-1:0]; b = tb_[W-1:0]; op = top[2:0]; in_valid = 1'b1;
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready i=%0d got=%b exp=1", i, in_ready); end
            @(posedge clk); #1;
            a = ~a; b = ~b;
            checks++;
            if ({out_valid, r_hi, r, N, Z, C, V} !== {1'b1, exp}) begin
                errors++;
                $display("FAIL b2b_result i=%0d got=%h exp=%h", i, {out_valid, r_hi, r, N, Z, C, V}, {1'b1, exp});
            end
            @(posedge clk); #1;
            checks++;
            if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL b2b_idle i=%0d got=%b exp=10", i, {in_ready, out_valid}); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (($time - t0) !== 160) begin errors++; $display("FAIL b2b_throughput got=%0t exp=160", $time - t0); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_shift();
        test_backpressure();
        test_reset_mid_mul();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
